// File: rtl/mem_port_arb_if.sv
// Handshake bundle between the core's I/D ports, the arbiter and system memory.
// Signal directions in the names are from the arbiter's point of view.
interface mem_port_arb_if;
  // instruction port
  logic        ireqready_o;
  logic        ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i;
  logic        irspvalid_o;
  logic        irsprerr_o;
  logic [31:0] irspdata_o;
  // data port
  logic        dreqready_o;
  logic        dreqvalid_i;
  logic [1:0]  dreqsize_i;
  logic        dreqdvalid_i;
  logic [1:0]  dreqhpl_i;
  logic [31:0] dreqaddr_i;
  logic [31:0] dreqdata_i;
  logic        drspready_i;
  logic        drspvalid_o;
  logic        drsprerr_o;
  logic        drspwerr_o;
  logic [31:0] drspdata_o;
  // memory port
  logic        mreqready_i;
  logic        mreqvalid_o;
  logic [1:0]  mreqsize_o;
  logic        mreqdvalid_o;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o;
  logic [31:0] mreqdata_o;
  logic        mrspready_o;
  logic        mrspvalid_i;
  logic        mrsprerr_i;
  logic        mrspwerr_i;
  logic [31:0] mrspdata_i;

  // Arbiter side
  modport slave (
    output ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
    input  ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
    output dreqready_o, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
    input  dreqvalid_i, dreqsize_i, dreqdvalid_i, dreqhpl_i, dreqaddr_i, dreqdata_i, drspready_i,
    input  mreqready_i, mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i,
    output mreqvalid_o, mreqsize_o, mreqdvalid_o, mreqhpl_o, mreqaddr_o, mreqdata_o, mrspready_o
  );

  // Core + memory side
  modport master (
    input  ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
    output ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i,
    input  dreqready_o, drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o,
    output dreqvalid_i, dreqsize_i, dreqdvalid_i, dreqhpl_i, dreqaddr_i, dreqdata_i, drspready_i,
    output mreqready_i, mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i,
    input  mreqvalid_o, mreqsize_o, mreqdvalid_o, mreqhpl_o, mreqaddr_o, mreqdata_o, mrspready_o
  );
endinterface

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one memory port between the instruction and data
// ports. Accepted requests are remembered by port ID in issue order so the
// in-order memory responses can be steered back to their originator.
module mem_port_arb #(
  parameter int unsigned C_OUTST_X = 2
) (
  input  logic          clk_i,
  input  logic          resetb_i,
  input  logic          clk_en_i,
  mem_port_arb_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** C_OUTST_X;
  localparam int unsigned PW    = C_OUTST_X;
  localparam int unsigned CW    = C_OUTST_X + 1;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  logic             gnt_q, gnt_d;
  logic             lock_q, lock_d;
  logic             rr_q, rr_d;
  logic [DEPTH-1:0] id_q, id_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic sel;
  logic sel_valid;
  logic mvalid;
  logic full;
  logic empty;
  logic head;
  logic push;
  logic pop;

  // Grant choice: a stalled request keeps its grant, otherwise round-robin on contention
  always_comb begin
    sel = gnt_q;
    if (!lock_q) begin
      if (bus.dreqvalid_i && !bus.ireqvalid_i) begin
        sel = ID_D;
      end else if (bus.ireqvalid_i && !bus.dreqvalid_i) begin
        sel = ID_I;
      end else if (bus.ireqvalid_i && bus.dreqvalid_i) begin
        sel = rr_q;
      end
    end
  end

  // Request forwarding to memory and per-port acceptance
  always_comb begin
    full      = (cnt_q == CW'(DEPTH));
    sel_valid = (sel == ID_D) ? bus.dreqvalid_i : bus.ireqvalid_i;
    mvalid    = sel_valid & ~full;

    bus.mreqvalid_o = mvalid;
    if (sel == ID_D) begin
      bus.mreqsize_o   = bus.dreqsize_i;
      bus.mreqdvalid_o = bus.dreqdvalid_i;
      bus.mreqhpl_o    = bus.dreqhpl_i;
      bus.mreqaddr_o   = bus.dreqaddr_i;
      bus.mreqdata_o   = bus.dreqdata_i;
    end else begin
      // fetches are always word reads
      bus.mreqsize_o   = 2'b10;
      bus.mreqdvalid_o = 1'b0;
      bus.mreqhpl_o    = bus.ireqhpl_i;
      bus.mreqaddr_o   = bus.ireqaddr_i;
      bus.mreqdata_o   = 32'h0;
    end

    bus.ireqready_o = mvalid & bus.mreqready_i & (sel == ID_I);
    bus.dreqready_o = mvalid & bus.mreqready_i & (sel == ID_D);
    push            = clk_en_i & mvalid & bus.mreqready_i;
  end

  // Response steering by the oldest outstanding ID
  always_comb begin
    empty = (cnt_q == '0);
    head  = id_q[rd_ptr_q];

    bus.mrspready_o = ~empty & ((head == ID_D) ? bus.drspready_i : bus.irspready_i);
    bus.irspvalid_o = ~empty & (head == ID_I) & bus.mrspvalid_i;
    bus.drspvalid_o = ~empty & (head == ID_D) & bus.mrspvalid_i;
    bus.irsprerr_o  = bus.mrsprerr_i;
    bus.irspdata_o  = bus.mrspdata_i;
    bus.drsprerr_o  = bus.mrsprerr_i;
    bus.drspwerr_o  = bus.mrspwerr_i;
    bus.drspdata_o  = bus.mrspdata_i;

    pop = clk_en_i & bus.mrspvalid_i & bus.mrspready_o;
  end

  // Next-state for grant, lock, round-robin pointer and order queue
  always_comb begin
    gnt_d    = gnt_q;
    lock_d   = lock_q;
    rr_d     = rr_q;
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (clk_en_i) begin
      gnt_d  = sel;
      // a presented but unaccepted request pins the grant
      lock_d = mvalid & ~bus.mreqready_i;
      if (push) begin
        rr_d           = ~sel;
        id_d[wr_ptr_q] = sel;
        wr_ptr_d       = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; data port is preferred first out of reset
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      gnt_q    <= ID_I;
      lock_q   <= 1'b0;
      rr_q     <= ID_D;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      gnt_q    <= gnt_d;
      lock_q   <= lock_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios followed by constrained-random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_port_arb;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic clk_en;

  mem_port_arb_if bus ();

  mem_port_arb #(.C_OUTST_X(2)) dut (
    .clk_i    (clk),
    .resetb_i (rst_n),
    .clk_en_i (clk_en),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: issue-order ID list, preferred port, stalled port (-1 none)
  bit id_q[$];
  bit rr_m;
  int stall_m;
  int mem_out;

  // observations recorded at each transfer
  bit dut_gnt[$];
  bit dut_rt[$];

  // per-cycle predictions / observations carried into the clock edge
  bit p_ce, p_mv, p_rdy, p_sel, p_pop;
  bit o_memacc, o_rsp, o_iacc, o_dacc, o_gnt, o_rt;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  task automatic idle_inputs();
    bus.ireqvalid_i  = 1'b0; bus.ireqhpl_i = 2'd0; bus.ireqaddr_i = 32'h0;
    bus.irspready_i  = 1'b0;
    bus.dreqvalid_i  = 1'b0; bus.dreqsize_i = 2'd0; bus.dreqdvalid_i = 1'b0;
    bus.dreqhpl_i    = 2'd0; bus.dreqaddr_i = 32'h0; bus.dreqdata_i = 32'h0;
    bus.drspready_i  = 1'b0;
    bus.mreqready_i  = 1'b0;
    bus.mrspvalid_i  = 1'b0; bus.mrsprerr_i = 1'b0; bus.mrspwerr_i = 1'b0;
    bus.mrspdata_i   = 32'h0;
    clk_en = 1'b1;
  endtask

  // Called away from the active edge; asserts reset, checks quiescent outputs.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_mreqvalid", bus.mreqvalid_o, 0);
    chk("rst_ireqready", bus.ireqready_o, 0);
    chk("rst_dreqready", bus.dreqready_o, 0);
    chk("rst_irspvalid", bus.irspvalid_o, 0);
    chk("rst_drspvalid", bus.drspvalid_o, 0);
    chk("rst_mrspready", bus.mrspready_o, 0);
    id_q.delete(); dut_gnt.delete(); dut_rt.delete();
    rr_m = 1'b1; stall_m = -1; mem_out = 0;
    o_memacc = 0; o_rsp = 0; o_iacc = 0; o_dacc = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Let inputs settle and compare every output against the model.
  task automatic settle();
    bit iv, dv, sel, any, full, head, exp_mr, exp_iv, exp_dv;
    #1;
    iv   = bus.ireqvalid_i;
    dv   = bus.dreqvalid_i;
    full = (id_q.size() == DEPTH);
    if (stall_m >= 0)    sel = (stall_m == 1);
    else if (iv && !dv)  sel = 1'b0;
    else if (dv && !iv)  sel = 1'b1;
    else                 sel = rr_m;
    any  = sel ? dv : iv;
    p_mv = any && !full;
    p_sel = sel;
    p_rdy = bus.mreqready_i;
    p_ce  = clk_en;

    chk("mreqvalid", bus.mreqvalid_o, p_mv);
    if (p_mv) begin
      if (sel) begin
        chk("mreqaddr_d", bus.mreqaddr_o, bus.dreqaddr_i);
        chk("mreqsize_d", bus.mreqsize_o, bus.dreqsize_i);
        chk("mreqdv_d", bus.mreqdvalid_o, bus.dreqdvalid_i);
        chk("mreqhpl_d", bus.mreqhpl_o, bus.dreqhpl_i);
        chk("mreqdata_d", bus.mreqdata_o, bus.dreqdata_i);
      end else begin
        chk("mreqaddr_i", bus.mreqaddr_o, bus.ireqaddr_i);
        chk("mreqsize_i", bus.mreqsize_o, 2'b10);
        chk("mreqdv_i", bus.mreqdvalid_o, 0);
        chk("mreqhpl_i", bus.mreqhpl_o, bus.ireqhpl_i);
        chk("mreqdata_i", bus.mreqdata_o, 0);
      end
    end
    chk("ireqready", bus.ireqready_o, p_mv && !sel && p_rdy);
    chk("dreqready", bus.dreqready_o, p_mv && sel && p_rdy);

    if (id_q.size() == 0) begin
      exp_mr = 0; exp_iv = 0; exp_dv = 0;
    end else begin
      head   = id_q[0];
      exp_mr = head ? bus.drspready_i : bus.irspready_i;
      exp_iv = !head && bus.mrspvalid_i;
      exp_dv = head && bus.mrspvalid_i;
    end
    chk("mrspready", bus.mrspready_o, exp_mr);
    chk("irspvalid", bus.irspvalid_o, exp_iv);
    chk("drspvalid", bus.drspvalid_o, exp_dv);
    if (exp_iv) begin
      chk("irspdata", bus.irspdata_o, bus.mrspdata_i);
      chk("irsprerr", bus.irsprerr_o, bus.mrsprerr_i);
    end
    if (exp_dv) begin
      chk("drspdata", bus.drspdata_o, bus.mrspdata_i);
      chk("drsprerr", bus.drsprerr_o, bus.mrsprerr_i);
      chk("drspwerr", bus.drspwerr_o, bus.mrspwerr_i);
    end
    p_pop = clk_en && bus.mrspvalid_i && exp_mr;

    o_memacc = clk_en && bus.mreqvalid_o && bus.mreqready_i;
    o_gnt    = bus.dreqready_o;
    o_iacc   = clk_en && bus.ireqvalid_i && bus.ireqready_o;
    o_dacc   = clk_en && bus.dreqvalid_i && bus.dreqready_o;
    o_rsp    = clk_en && bus.mrspvalid_i && bus.mrspready_o;
    o_rt     = bus.drspvalid_o;
  endtask

  // Advance one clock and update the model with the transfers that happened.
  task automatic clock();
    @(posedge clk);
    if (p_ce) begin
      if (p_mv && p_rdy) begin
        id_q.push_back(p_sel);
        rr_m = !p_sel;
        stall_m = -1;
      end else if (p_mv) begin
        stall_m = p_sel ? 1 : 0;
      end else begin
        stall_m = -1;
      end
      if (p_pop) void'(id_q.pop_front());
    end
    if (o_memacc) begin
      mem_out++;
      dut_gnt.push_back(o_gnt);
    end
    if (o_rsp) begin
      if (mem_out > 0) mem_out--;
      dut_rt.push_back(o_rt);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    clock();
  endtask

  // Random requesters hold a request until accepted; memory holds a response until taken.
  task automatic drive_random(int pi, int pd, int pm, int pr);
    if (!bus.ireqvalid_i || o_iacc) begin
      bus.ireqvalid_i = ($urandom_range(99) < pi);
      bus.ireqaddr_i  = $urandom;
      bus.ireqhpl_i   = 2'($urandom);
    end
    if (!bus.dreqvalid_i || o_dacc) begin
      bus.dreqvalid_i  = ($urandom_range(99) < pd);
      bus.dreqaddr_i   = $urandom;
      bus.dreqdata_i   = $urandom;
      bus.dreqsize_i   = 2'($urandom);
      bus.dreqdvalid_i = 1'($urandom);
      bus.dreqhpl_i    = 2'($urandom);
    end
    bus.mreqready_i = ($urandom_range(99) < pm);
    bus.irspready_i = ($urandom_range(99) < 70);
    bus.drspready_i = ($urandom_range(99) < 70);
    if (!bus.mrspvalid_i || o_rsp) begin
      if (mem_out > 0) bus.mrspvalid_i = ($urandom_range(99) < pr);
      else             bus.mrspvalid_i = ($urandom_range(99) < 5);
      bus.mrspdata_i = $urandom;
      bus.mrsprerr_i = 1'($urandom);
      bus.mrspwerr_i = 1'($urandom);
    end
    clk_en = ($urandom_range(9) != 0);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // idle with a spurious memory response
    bus.mrspvalid_i = 1'b1; bus.irspready_i = 1'b1; bus.drspready_i = 1'b1;
    settle();
    chk("idle_mrspready", bus.mrspready_o, 0);
    clock();
    idle_inputs();

    // single instruction fetch
    bus.ireqvalid_i = 1'b1; bus.ireqaddr_i = 32'h100; bus.ireqhpl_i = 2'd3;
    bus.mreqready_i = 1'b1;
    settle();
    chk("fetch_addr", bus.mreqaddr_o, 32'h100);
    chk("fetch_size", bus.mreqsize_o, 2'b10);
    chk("fetch_irdy", bus.ireqready_o, 1);
    clock();
    bus.ireqvalid_i = 1'b0; bus.mreqready_i = 1'b0;
    bus.mrspvalid_i = 1'b1; bus.mrspdata_i = 32'hDEADBEEF; bus.irspready_i = 1'b1;
    settle();
    chk("fetch_rspv", bus.irspvalid_o, 1);
    chk("fetch_rspd", bus.irspdata_o, 32'hDEADBEEF);
    chk("fetch_drspv", bus.drspvalid_o, 0);
    clock();

    // contention fills the queue, then one pop frees a slot
    do_reset();
    bus.ireqvalid_i = 1'b1; bus.dreqvalid_i = 1'b1; bus.mreqready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.ireqaddr_i = 32'h1000 + 32'(k); bus.dreqaddr_i = 32'h3000 + 32'(k);
      step();
    end
    chk("cont_ngnt", 32'(dut_gnt.size()), 4);
    if (dut_gnt.size() == 4) begin
      chk("cont_g0", dut_gnt[0], 1);
      chk("cont_g1", dut_gnt[1], 0);
      chk("cont_g2", dut_gnt[2], 1);
      chk("cont_g3", dut_gnt[3], 0);
    end
    bus.mrspvalid_i = 1'b1; bus.irspready_i = 1'b1; bus.drspready_i = 1'b1;
    bus.mrspdata_i = 32'h11;
    settle();
    chk("full_block", bus.mreqvalid_o, 0);
    chk("full_pop", bus.mrspready_o, 1);
    clock();
    bus.mrspdata_i = 32'h22;
    settle();
    chk("full_retry", bus.mreqvalid_o, 1);
    clock();
    bus.ireqvalid_i = 1'b0; bus.dreqvalid_i = 1'b0;
    for (int k = 0; k < 10 && id_q.size() > 0; k++) begin
      bus.mrspdata_i = 32'h33 + 32'(k);
      step();
    end
    chk("drain_nrt", 32'(dut_rt.size()), 5);
    if (dut_rt.size() >= 4) begin
      chk("route0", dut_rt[0], 1);
      chk("route1", dut_rt[1], 0);
      chk("route2", dut_rt[2], 1);
      chk("route3", dut_rt[3], 0);
    end
    idle_inputs();

    // hold: D stalled three cycles with I also pending
    do_reset();
    bus.dreqvalid_i = 1'b1; bus.dreqaddr_i = 32'h2000; bus.dreqsize_i = 2'b10;
    bus.ireqvalid_i = 1'b1; bus.ireqaddr_i = 32'h100;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hold_addr", bus.mreqaddr_o, 32'h2000);
      chk("hold_drdy", bus.dreqready_o, 0);
      clock();
    end
    bus.mreqready_i = 1'b1;
    settle();
    chk("hold_accept", bus.dreqready_o, 1);
    clock();
    bus.dreqaddr_i = 32'h2004;
    settle();
    chk("hold_next_i", bus.ireqready_o, 1);
    chk("hold_next_addr", bus.mreqaddr_o, 32'h100);
    clock();
    idle_inputs();

    // lock beats round-robin preference when D arrives during an I stall
    do_reset();
    bus.ireqvalid_i = 1'b1; bus.ireqaddr_i = 32'h400;
    step();
    bus.dreqvalid_i = 1'b1; bus.dreqaddr_i = 32'h500;
    settle();
    chk("lock_addr", bus.mreqaddr_o, 32'h400);
    clock();
    bus.mreqready_i = 1'b1;
    settle();
    chk("lock_irdy", bus.ireqready_o, 1);
    clock();
    idle_inputs();

    // store with write error
    do_reset();
    bus.dreqvalid_i = 1'b1; bus.dreqaddr_i = 32'h80; bus.dreqsize_i = 2'b00;
    bus.dreqdvalid_i = 1'b1; bus.dreqdata_i = 32'hA5; bus.mreqready_i = 1'b1;
    settle();
    chk("st_data", bus.mreqdata_o, 32'hA5);
    chk("st_dvalid", bus.mreqdvalid_o, 1);
    clock();
    bus.dreqvalid_i = 1'b0; bus.mreqready_i = 1'b0;
    bus.mrspvalid_i = 1'b1; bus.mrspwerr_i = 1'b1; bus.drspready_i = 1'b1;
    settle();
    chk("st_rspv", bus.drspvalid_o, 1);
    chk("st_werr", bus.drspwerr_o, 1);
    clock();
    settle();
    chk("st_empty", bus.mrspready_o, 0);
    clock();
    idle_inputs();

    // random traffic in a few load mixes
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      case (k / 1000)
        0:       drive_random(60, 60, 70, 60);
        1:       drive_random(90, 90, 90, 15);
        default: drive_random(40, 70, 30, 80);
      endcase
      step();
    end

    // reset with requests in flight
    do_reset();
    bus.mrspvalid_i = 1'b1; bus.irspready_i = 1'b1; bus.drspready_i = 1'b1;
    settle();
    chk("post_rst_mrspready", bus.mrspready_o, 0);
    clock();
    for (int k = 0; k < 300; k++) begin
      drive_random(70, 70, 60, 50);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
